// File: rtl/fnd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : fnd_pkg                                                    |
// | Description : Shared definitions for the 4-digit FND display bus:        |
// |               segment glyphs (active-low {g,f,e,d,c,b,a}), digit-select  |
// |               codes (active-low one-hot) and value reassembly helpers.   |
// |               Imported by both the display controller and the capture    |
// |               block so the glyph tables cannot diverge.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fnd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int VALUE_W    = 14;
  localparam int NUM_DIGITS = 4;

  // Segment glyphs on font[6:0], active-low.
  localparam logic [6:0] FONT_0 = 7'h40;
  localparam logic [6:0] FONT_1 = 7'h79;
  localparam logic [6:0] FONT_2 = 7'h24;
  localparam logic [6:0] FONT_3 = 7'h30;
  localparam logic [6:0] FONT_4 = 7'h19;
  localparam logic [6:0] FONT_5 = 7'h12;
  localparam logic [6:0] FONT_6 = 7'h02;
  localparam logic [6:0] FONT_7 = 7'h78;
  localparam logic [6:0] FONT_8 = 7'h00;
  localparam logic [6:0] FONT_9 = 7'h10;

  // Digit selects, active-low; DIG0 = ones ... DIG3 = thousands.
  localparam logic [3:0] SEL_DIG0  = 4'b1110;
  localparam logic [3:0] SEL_DIG1  = 4'b1101;
  localparam logic [3:0] SEL_DIG2  = 4'b1011;
  localparam logic [3:0] SEL_DIG3  = 4'b0111;
  localparam logic [3:0] SEL_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    SEL_IS_BLANK = 2'd0,
    SEL_IS_DIGIT = 2'd1,
    SEL_IS_BAD   = 2'd2
  } sel_kind_e;

  function automatic sel_kind_e sel_kind(input logic [3:0] sel);
    case (sel)
      SEL_BLANK:                               return SEL_IS_BLANK;
      SEL_DIG0, SEL_DIG1, SEL_DIG2, SEL_DIG3:  return SEL_IS_DIGIT;
      default:                                 return SEL_IS_BAD;
    endcase
  endfunction

  // Only meaningful when sel_kind() reports SEL_IS_DIGIT.
  function automatic logic [1:0] sel_index(input logic [3:0] sel);
    case (sel)
      SEL_DIG1: return 2'd1;
      SEL_DIG2: return 2'd2;
      SEL_DIG3: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  // Digits are always 0..9 here, so the sum stays within 9999.
  function automatic logic [VALUE_W-1:0] bcd_to_bin(
    input logic [NUM_DIGITS-1:0][DIGIT_W-1:0] d
  );
    return VALUE_W'(d[3]) * VALUE_W'(1000) +
           VALUE_W'(d[2]) * VALUE_W'(100)  +
           VALUE_W'(d[1]) * VALUE_W'(10)   +
           VALUE_W'(d[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_font_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fnd_font_decoder                                           |
// | Description : Combinational 7-segment glyph to BCD digit decoder.        |
// | Ports       : i_font  [6:0]  active-low segments {g,f,e,d,c,b,a}         |
// |               o_valid        glyph is one of the ten digit shapes        |
// |               o_digit [3:0]  decoded digit (0 when not valid)            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [6:0]         i_font,
  output logic               o_valid,
  output logic [DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_valid = 1'b1;
    o_digit = '0;
    case (i_font)
      FONT_0:  o_digit = DIGIT_W'(0);
      FONT_1:  o_digit = DIGIT_W'(1);
      FONT_2:  o_digit = DIGIT_W'(2);
      FONT_3:  o_digit = DIGIT_W'(3);
      FONT_4:  o_digit = DIGIT_W'(4);
      FONT_5:  o_digit = DIGIT_W'(5);
      FONT_6:  o_digit = DIGIT_W'(6);
      FONT_7:  o_digit = DIGIT_W'(7);
      FONT_8:  o_digit = DIGIT_W'(8);
      FONT_9:  o_digit = DIGIT_W'(9);
      default: o_valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fnd_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fnd_capture                                                |
// | Description : Passive monitor of the multiplexed 4-digit FND bus.        |
// |               Captures each digit once it has settled, and when all four |
// |               digits have been seen reports the reassembled decimal      |
// |               value, an error flag for the frame, and a stall flag when  |
// |               the bus stops producing captures.                          |
// | Ports       : i_clk               system clock                           |
// |               i_reset             asynchronous reset, active low         |
// |               i_fndSelect [3:0]   digit select, active-low one-hot       |
// |               i_fndFont   [7:0]   segments {dp,g,f,e,d,c,b,a}, active-low|
// |               o_value     [13:0]  last reassembled value                 |
// |               o_valid             one-cycle pulse on value/error update  |
// |               o_error             error status of the reported frame     |
// |               o_stall             no capture for TIMEOUT_CYCLES          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fnd_capture
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [3:0]         i_fndSelect,
  input  logic [7:0]         i_fndFont,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_valid,
  output logic               o_error,
  output logic               o_stall
);

  localparam int c_STAB_W = $clog2(SETTLE_CYCLES + 1);
  localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(SETTLE_CYCLES);
  // The counter sits at SETTLE-2 in the cycle where it is about to reach
  // SETTLE-1, i.e. the inputs have been steady for SETTLE cycles.
  localparam logic [c_STAB_W-1:0] c_STAB_HIT = c_STAB_W'(SETTLE_CYCLES - 2);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(TIMEOUT_CYCLES);

  // Input stage and one-cycle-delayed copy for change detection.
  logic [3:0]          r_sel;
  logic [7:0]          r_font;
  logic [3:0]          r_prev_sel;
  logic [7:0]          r_prev_font;
  logic [c_STAB_W-1:0] r_stab;
  logic [c_IDLE_W-1:0] r_idle;

  // Frame assembly state.
  logic [NUM_DIGITS-1:0]              r_seen;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_digit;
  logic                               r_frame_err;
  logic                               r_pend;
  logic                               r_pend_err;

  // Output registers.
  logic [VALUE_W-1:0] r_value;
  logic               r_valid;
  logic               r_error;
  logic               r_stall;

  logic                               w_same;
  logic                               w_capture;
  logic                               w_active_cap;
  logic                               w_timeout;
  sel_kind_e                          w_kind;
  logic [1:0]                         w_idx;
  logic                               w_glyph_ok;
  logic [DIGIT_W-1:0]                 w_glyph_digit;
  logic [c_STAB_W-1:0]                w_stab_next;
  logic [c_IDLE_W-1:0]                w_idle_next;
  logic [NUM_DIGITS-1:0]              w_seen_next;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_digit_next;
  logic                               w_err_next;
  logic                               w_done;
  logic                               w_done_err;

  fnd_font_decoder u_font_decoder (
    .i_font  (r_font[6:0]),
    .o_valid (w_glyph_ok),
    .o_digit (w_glyph_digit)
  );

  assign w_same = (r_sel == r_prev_sel) && (r_font == r_prev_font);

  // The counter passes through c_STAB_HIT only once per dwell before it
  // saturates above it, so each dwell yields at most one capture.
  assign w_capture = w_same && (r_stab == c_STAB_HIT);
  assign w_kind    = sel_kind(r_sel);
  assign w_idx     = sel_index(r_sel);

  // Blank captures are ignored entirely and do not restart the idle timer.
  assign w_active_cap = w_capture && (w_kind != SEL_IS_BLANK);

  always_comb begin
    w_stab_next = r_stab;
    if (!w_same) begin
      w_stab_next = '0;
    end else if (r_stab != c_STAB_MAX) begin
      w_stab_next = r_stab + c_STAB_W'(1);
    end
  end

  always_comb begin
    w_idle_next = r_idle;
    if (w_active_cap) begin
      w_idle_next = '0;
    end else if (r_idle != c_IDLE_MAX) begin
      w_idle_next = r_idle + c_IDLE_W'(1);
    end
  end

  assign w_timeout = !w_active_cap && (w_idle_next == c_IDLE_MAX);

  always_comb begin
    w_seen_next  = r_seen;
    w_digit_next = r_digit;
    w_err_next   = r_frame_err;
    w_done       = 1'b0;
    w_done_err   = 1'b0;
    if (w_timeout) begin
      // A stalled bus abandons whatever partial frame was collected.
      w_seen_next = '0;
      w_err_next  = 1'b0;
    end else if (w_capture) begin
      case (w_kind)
        SEL_IS_DIGIT: begin
          w_digit_next[w_idx] = w_glyph_ok ? w_glyph_digit : '0;
          w_err_next          = r_frame_err | ~w_glyph_ok;
          w_seen_next         = r_seen | (NUM_DIGITS'(1) << w_idx);
          if (w_seen_next == '1) begin
            w_done      = 1'b1;
            w_done_err  = w_err_next;
            w_seen_next = '0;
            w_err_next  = 1'b0;
          end
        end
        SEL_IS_BAD: begin
          w_err_next = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sel       <= SEL_BLANK;
      r_font      <= 8'hFF;
      r_prev_sel  <= SEL_BLANK;
      r_prev_font <= 8'hFF;
      r_stab      <= '0;
      r_idle      <= '0;
      r_seen      <= '0;
      r_digit     <= '0;
      r_frame_err <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_err  <= 1'b0;
      r_value     <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      r_sel       <= i_fndSelect;
      r_font      <= i_fndFont;
      r_prev_sel  <= r_sel;
      r_prev_font <= r_font;
      r_stab      <= w_stab_next;
      r_idle      <= w_idle_next;
      r_seen      <= w_seen_next;
      r_digit     <= w_digit_next;
      r_frame_err <= w_err_next;
      r_pend      <= w_done;
      r_pend_err  <= w_done_err;
      // Digits cannot change in the cycle after completion (next capture is
      // at least SETTLE cycles away), so the sum is taken one cycle later.
      r_valid     <= r_pend;
      if (r_pend) begin
        r_value <= bcd_to_bin(r_digit);
        r_error <= r_pend_err;
      end
      if (w_active_cap) begin
        r_stall <= 1'b0;
      end else if (w_idle_next == c_IDLE_MAX) begin
        r_stall <= 1'b1;
      end
    end
  end

  assign o_value = r_value;
  assign o_valid = r_valid;
  assign o_error = r_error;
  assign o_stall = r_stall;

endmodule
`default_nettype wire
